md_issue_ctrl: RTL and testbench

- Initiator-side controller for the multiply/divide unit. Sits in the E stage of the pipeline.
- Decodes the E-stage instruction and drives the unit's Start/Instr inputs for MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Tracks the unit's Busy response against expected latency and produces a D-stage stall, a completion pulse and a sticky protocol-error flag.
- The register file and hazard unit consume stall_md and md_done.

---
 rtl/md_issue_ctrl_pkg.sv | 28 ++
 rtl/md_issue_ctrl_decode.sv | 28 ++
 rtl/md_issue_ctrl.sv | 119 +++++++++++
 tb/tb_md_issue_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/md_issue_ctrl_pkg.sv
// Shared definitions for the mul/div issue controller:
// opcode/funct codes, FSM states and instruction classes.
package md_issue_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_MUL  = 2'd0,
    CLS_DIV  = 2'd1,
    CLS_MOVE = 2'd2,
    CLS_NONE = 2'd3
  } md_class_t;

endpackage

// File: rtl/md_issue_ctrl_decode.sv
// Combinational mul/div instruction classifier.
// Only the opcode and funct fields matter here.
module md_decode
  import md_issue_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_md,
  output logic [1:0]  cls
);

  logic unused_fields;
  assign unused_fields = ^instr[25:6];

  always_comb begin
    cls = CLS_NONE;
    if (instr[31:26] == OP_SPECIAL) begin
      unique case (instr[5:0])
        FUNCT_MULT, FUNCT_MULTU: cls = CLS_MUL;
        FUNCT_DIV, FUNCT_DIVU:   cls = CLS_DIV;
        FUNCT_MFHI, FUNCT_MTHI,
        FUNCT_MFLO, FUNCT_MTLO:  cls = CLS_MOVE;
        default:                 cls = CLS_NONE;
      endcase
    end
    is_md = (cls != CLS_NONE);
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the mul/div unit: start,
// busy tracking against expected latency, stall and errors.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 5,
  parameter int SLACK      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_e,
  input  logic        valid_e,
  input  logic        flush_e,
  input  logic [31:0] instr_d,
  input  logic        md_busy,
  output logic        md_start,
  output logic [31:0] md_instr,
  output logic        stall_md,
  output logic        md_done,
  output logic        md_err
);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] exp_q, exp_n;
  logic [CNT_W-1:0] cnt_inc, lim;
  logic             err_n;
  logic             is_md_e, is_md_d;
  logic [1:0]       cls_e, cls_d;
  logic             e_req;
  logic             unused_cls_d;

  md_decode u_dec_e (
    .instr (instr_e),
    .is_md (is_md_e),
    .cls   (cls_e)
  );

  md_decode u_dec_d (
    .instr (instr_d),
    .is_md (is_md_d),
    .cls   (cls_d)
  );

  assign unused_cls_d = ^cls_d;
  assign e_req   = is_md_e & valid_e;
  assign cnt_inc = cnt + CNT_W'(1);
  assign lim     = exp_q + CNT_W'(SLACK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      exp_q  <= '0;
      md_err <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      exp_q  <= exp_n;
      md_err <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    exp_n   = exp_q;
    err_n   = md_err;
    unique case (state)
      IDLE: begin
        if (md_busy) err_n = 1'b1;
        if (md_start) begin
          unique case (1'b1)
            (cls_e == CLS_MUL): begin
              state_n = WAIT;
              exp_n   = CNT_W'(MUL_CYCLES);
              cnt_n   = '0;
            end
            (cls_e == CLS_DIV): begin
              state_n = WAIT;
              exp_n   = CNT_W'(DIV_CYCLES);
              cnt_n   = '0;
            end
            default: state_n = DONE;
          endcase
        end
      end
      WAIT: begin
        if (e_req) err_n = 1'b1;
        if (md_busy) begin
          cnt_n = cnt_inc;
          // Unit stuck busy: give up and report.
          if (cnt_inc == lim) begin
            err_n   = 1'b1;
            state_n = DONE;
          end
        end else begin
          state_n = DONE;
          if (cnt != exp_q) err_n = 1'b1;
        end
      end
      DONE: begin
        if (e_req) err_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    md_start = e_req & ~flush_e & (state == IDLE);
    md_instr = md_start ? instr_e : 32'd0;
    stall_md = is_md_d & (md_start | (state != IDLE));
    md_done  = (state == DONE);
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl; expected outputs are
// queued per driven cycle and checked mid-cycle.
module tb_md_issue_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] instr_e;
  logic        valid_e;
  logic        flush_e;
  logic [31:0] instr_d;
  logic        md_busy;
  logic        md_start;
  logic [31:0] md_instr;
  logic        stall_md;
  logic        md_done;
  logic        md_err;

  int n_vec;
  int n_bad;

  typedef struct {
    logic        start;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] mi;
  } exp_t;

  exp_t sb[$];

  md_issue_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .instr_e  (instr_e),
    .valid_e  (valid_e),
    .flush_e  (flush_e),
    .instr_d  (instr_d),
    .md_busy  (md_busy),
    .md_start (md_start),
    .md_instr (md_instr),
    .stall_md (stall_md),
    .md_done  (md_done),
    .md_err   (md_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] op,
                                     input logic [5:0] fn);
    return {op, 5'd4, 5'd5, 5'd6, 5'd0, fn};
  endfunction

  localparam logic [31:0] MULT = {6'd0, 5'd4, 5'd5, 10'd0, 6'b011000};
  localparam logic [31:0] DIV  = {6'd0, 5'd4, 5'd5, 10'd0, 6'b011010};
  localparam logic [31:0] DIVU = {6'd0, 5'd4, 5'd5, 10'd0, 6'b011011};
  localparam logic [31:0] MFHI = {6'd0, 10'd0, 5'd7, 5'd0, 6'b010000};
  localparam logic [31:0] MFLO = {6'd0, 10'd0, 5'd7, 5'd0, 6'b010010};
  localparam logic [31:0] MTHI = {6'd0, 5'd4, 15'd0, 6'b010001};
  localparam logic [31:0] MTLO = {6'd0, 5'd4, 15'd0, 6'b010011};
  localparam logic [31:0] ADDU = {6'd0, 5'd4, 5'd5, 5'd6, 5'd0, 6'b100001};

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] x);
    n_vec++;
    assert (o === x) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h at %0t",
             tag, o, x, $time);
    end
  endtask

  task automatic step(input logic r, input logic [31:0] ie,
                      input logic v, input logic f,
                      input logic [31:0] id, input logic b,
                      input logic es, input logic est,
                      input logic ed, input logic eer);
    exp_t e;
    reset   = r;
    instr_e = ie;
    valid_e = v;
    flush_e = f;
    instr_d = id;
    md_busy = b;
    sb.push_back('{es, est, ed, eer, es ? ie : 32'd0});
    @(negedge clk);
    e = sb.pop_front();
    chk("md_start", {31'd0, md_start}, {31'd0, e.start});
    chk("md_instr", md_instr, e.mi);
    chk("stall_md", {31'd0, stall_md}, {31'd0, e.stall});
    chk("md_done", {31'd0, md_done}, {31'd0, e.done});
    chk("md_err", {31'd0, md_err}, {31'd0, e.err});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] addi_like;
    n_vec = 0;
    n_bad = 0;
    addi_like = mk(6'b001000, 6'b011000);
    reset = 1'b1;
    instr_e = '0;
    valid_e = 1'b0;
    flush_e = 1'b0;
    instr_d = '0;
    md_busy = 1'b0;
    @(posedge clk);
    #1;
    // reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // MULT, busy 5 cycles, done at T+7
    step(0, MULT, 1, 0, ADDU, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 0, ADDU, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, ADDU, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, ADDU, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, ADDU, 0, 0, 0, 0, 0);

    // DIVU with MFLO behind it in D
    step(0, DIVU, 1, 0, MFLO, 0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++)
      step(0, 0, 0, 0, MFLO, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, MFLO, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, MFLO, 0, 0, 1, 1, 0);
    step(0, MFLO, 1, 0, ADDU, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, ADDU, 0, 0, 0, 1, 0);

    // MTHI with md in D, MTLO with ADDU in D
    step(0, MTHI, 1, 0, MULT, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, MULT, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, MULT, 0, 0, 0, 0, 0);
    step(0, MTLO, 1, 0, ADDU, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, ADDU, 0, 0, 0, 1, 0);
    step(0, addi_like, 1, 0, ADDU, 0, 0, 0, 0, 0);
    step(0, MFHI, 0, 0, MULT, 0, 0, 0, 0, 0);

    // flush suppresses start, FSM stays idle
    step(0, MULT, 1, 1, ADDU, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, MULT, 0, 0, 0, 0, 0);

    // reset at WAIT cycle 3
    step(0, MULT, 1, 0, ADDU, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, MULT, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, MULT, 1, 0, 1, 0, 0);
    step(1, 0, 0, 0, MULT, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, MULT, 0, 0, 0, 0, 0);

    // DIV timeout after 14 busy cycles
    step(0, DIV, 1, 0, ADDU, 0, 1, 0, 0, 0);
    for (int i = 0; i < 14; i++)
      step(0, 0, 0, 0, ADDU, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, ADDU, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, MULT, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, ADDU, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, ADDU, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, ADDU, 0, 0, 0, 0, 0);

    // busy while idle
    step(0, 0, 0, 0, MULT, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, MULT, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, ADDU, 0, 0, 0, 0, 1);

    // md in E while WAIT: start suppressed, error
    step(0, MULT, 1, 0, ADDU, 0, 1, 0, 0, 0);
    step(0, MFHI, 1, 0, ADDU, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, ADDU, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, ADDU, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, ADDU, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, ADDU, 0, 0, 0, 0, 1);

    // busy drops early: latency error
    step(0, MULT, 1, 0, ADDU, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, ADDU, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, ADDU, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, ADDU, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, ADDU, 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
